// File: rtl/axi_ad7124_chbuf.sv
// AD7124 channel frame buffer.
// Collects one conversion per channel into a write bank. Once every channel
// of a frame has arrived, the banks are swapped so the completed frame can be
// read through a simple BRAM-style port while the next frame is collected.
module axi_ad7124_chbuf #(
  parameter int NUM_CH    = 8,     // channels per frame, 2..8
  parameter bit STATUS_EN = 1'b1   // place the status byte in word[31:24]
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_valid,
  input  logic [23:0] s_data,
  input  logic [7:0]  s_status,
  input  logic        bram_clk,
  input  logic        bram_rst,
  input  logic        bram_en,
  input  logic [2:0]  bram_addr,
  output logic [31:0] bram_dout,
  output logic        drdy,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic        err_flag
);

  localparam int                IDX_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam logic [4:0]        CH_LIM = 5'(NUM_CH);
  localparam logic [NUM_CH-1:0] FULL   = {NUM_CH{1'b1}};

  // Frame state
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              bank_sel_q, bank_sel_d;   // write bank index; read bank is the other one
  logic [31:0]       bank_q [2][NUM_CH];
  logic [31:0]       bank_d [2][NUM_CH];

  // Output state
  logic [31:0] dout_q, dout_d;
  logic        drdy_q, drdy_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        err_q, err_d;

  // Decoded sample fields
  logic [3:0]       ch;
  logic             ch_ok;
  logic [IDX_W-1:0] ch_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_ok;
  logic [31:0]      wr_word;

  // The BRAM-side clock and reset exist only for IP packaging; all logic runs on clk.
  logic unused_bram;
  assign unused_bram = bram_clk ^ bram_rst;

  assign ch      = s_status[3:0];
  assign ch_ok   = {1'b0, ch} < CH_LIM;
  assign ch_idx  = ch[IDX_W-1:0];
  assign rd_ok   = {2'b00, bram_addr} < CH_LIM;
  assign rd_idx  = bram_addr[IDX_W-1:0];
  assign wr_word = {(STATUS_EN ? s_status : 8'h00), s_data};

  // Next-state: frame completion, sample capture and registered read.
  // NOTE: every variable gets a default at the top of always_comb, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    mask_d      = mask_q;
    bank_sel_d  = bank_sel_q;
    bank_d      = bank_q;
    dout_d      = dout_q;
    drdy_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    err_d       = err_q;

    // A mask that filled up on the previous edge is retired now: the banks
    // swap and collection restarts. A sample arriving on this same edge
    // lands in the new write bank on top of the cleared mask.
    if (mask_q == FULL) begin
      bank_sel_d  = ~bank_sel_q;
      mask_d      = '0;
      frame_cnt_d = frame_cnt_q + 16'd1;
      drdy_d      = 1'b1;
    end

    if (s_valid) begin
      if (s_status[6]) begin
        err_d = 1'b1;
      end
      if (!ch_ok) begin
        err_d = 1'b1;
      end else begin
        // Channel 0 while a frame is in progress restarts the frame.
        if ((ch == 4'd0) && (mask_d != '0)) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          mask_d     = '0;
        end
        bank_d[bank_sel_d][ch_idx] = wr_word;
        mask_d[ch_idx]             = 1'b1;
      end
    end

    // Reads use the pre-swap read bank, so a read on the swap edge still
    // returns the previous frame.
    if (bram_en) begin
      dout_d = rd_ok ? bank_q[~bank_sel_q][rd_idx] : 32'h0;
    end
  end

  // State registers with asynchronous active-low reset.
  // NOTE: the bank storage is reset along with the control state so a read
  // issued before the first frame returns zeros rather than stale contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mask_q      <= '0;
      bank_sel_q  <= 1'b0;
      dout_q      <= '0;
      drdy_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      err_q       <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_CH; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      mask_q      <= mask_d;
      bank_sel_q  <= bank_sel_d;
      dout_q      <= dout_d;
      drdy_q      <= drdy_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      err_q       <= err_d;
      bank_q      <= bank_d;
    end
  end

  assign bram_dout = dout_q;
  assign drdy      = drdy_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign err_flag  = err_q;

endmodule

// File: tb/tb_axi_ad7124_chbuf.sv
// Self-checking bench for axi_ad7124_chbuf: a table of per-cycle vectors for
// the 8-channel instance plus hand-written sequences for reset and the
// 4-channel, status-disabled instance.
module tb_axi_ad7124_chbuf;

  logic        clk;
  logic        resetn;

  // 8-channel instance
  logic        s_valid;
  logic [23:0] s_data;
  logic [7:0]  s_status;
  logic        bram_en;
  logic [2:0]  bram_addr;
  logic [31:0] bram_dout;
  logic        drdy;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        err_flag;

  // 4-channel instance, status byte disabled
  logic        s_valid_4;
  logic [23:0] s_data_4;
  logic [7:0]  s_status_4;
  logic        bram_en_4;
  logic [2:0]  bram_addr_4;
  logic [31:0] bram_dout_4;
  logic        drdy_4;
  logic [15:0] frame_cnt_4;
  logic [15:0] drop_cnt_4;
  logic        err_flag_4;

  int n_vec;
  int n_bad;

  axi_ad7124_chbuf #(.NUM_CH(8), .STATUS_EN(1'b1)) u_dut8 (
    .clk       (clk),
    .resetn    (resetn),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_status  (s_status),
    .bram_clk  (clk),
    .bram_rst  (1'b0),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .drdy      (drdy),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt),
    .err_flag  (err_flag)
  );

  axi_ad7124_chbuf #(.NUM_CH(4), .STATUS_EN(1'b0)) u_dut4 (
    .clk       (clk),
    .resetn    (resetn),
    .s_valid   (s_valid_4),
    .s_data    (s_data_4),
    .s_status  (s_status_4),
    .bram_clk  (clk),
    .bram_rst  (1'b0),
    .bram_en   (bram_en_4),
    .bram_addr (bram_addr_4),
    .bram_dout (bram_dout_4),
    .drdy      (drdy_4),
    .frame_cnt (frame_cnt_4),
    .drop_cnt  (drop_cnt_4),
    .err_flag  (err_flag_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  st;
    logic [23:0] d;
    logic        en;
    logic [2:0]  a;
    logic        chk;    // compare bram_dout on this vector
    logic [31:0] dout;
    logic        drdy;
    logic [15:0] fc;
    logic [15:0] dc;
    logic        err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] st, input logic [23:0] d,
                     input logic en, input logic [2:0] a, input logic chk,
                     input logic [31:0] dout, input logic dr, input logic [15:0] fc,
                     input logic [15:0] dc, input logic err, input string name);
    vec_t t;
    t.v = v; t.st = st; t.d = d; t.en = en; t.a = a; t.chk = chk; t.dout = dout;
    t.drdy = dr; t.fc = fc; t.dc = dc; t.err = err; t.name = name;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Safety net: the run is a fixed number of cycles, far below this bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    resetn = 1'b0;
    s_valid = 1'b0; s_data = '0; s_status = '0; bram_en = 1'b0; bram_addr = '0;
    s_valid_4 = 1'b0; s_data_4 = '0; s_status_4 = '0; bram_en_4 = 1'b0; bram_addr_4 = '0;

    // ---- vector table ----
    // Frame 1: channels 0..7 in order, status = channel.
    for (int k = 0; k < 8; k++)
      add(1, 8'(k), 24'h800000 + 24'(k), 0, 0, 0, 32'h0, 0, 16'd0, 16'd0, 0, "f1_wr");
    add(0, 0, 0, 0, 0, 0, 32'h0, 1, 16'd1, 16'd0, 0, "f1_drdy");
    for (int k = 0; k < 8; k++)
      add(0, 0, 0, 1, 3'(k), 1, {8'(k), 24'h800000 + 24'(k)}, 0, 16'd1, 16'd0, 0, "f1_rd");
    add(0, 0, 0, 0, 3'd2, 1, 32'h07800007, 0, 16'd1, 16'd0, 0, "f1_hold");

    // Partial frame 0,1,2 then a full frame: one drop, read bank untouched meanwhile.
    for (int k = 0; k < 3; k++)
      add(1, 8'(k), 24'h100000 + 24'(k), 1, 3'd2, 1, 32'h02800002, 0, 16'd1, 16'd0, 0, "p_wr");
    add(1, 8'h00, 24'h200000, 0, 0, 0, 32'h0, 0, 16'd1, 16'd1, 0, "p_drop");
    for (int k = 1; k < 8; k++)
      add(1, 8'(k), 24'h200000 + 24'(k), 0, 0, 0, 32'h0, 0, 16'd1, 16'd1, 0, "f2_wr");
    add(0, 0, 0, 0, 0, 0, 32'h0, 1, 16'd2, 16'd1, 0, "f2_drdy");
    add(0, 0, 0, 1, 3'd1, 1, 32'h01200001, 0, 16'd2, 16'd1, 0, "f2_rd1");
    add(0, 0, 0, 1, 3'd0, 1, 32'h00200000, 0, 16'd2, 16'd1, 0, "f2_rd0");

    // Continuous reads of addr 5 across a swap; a sample in the drdy cycle starts frame 4.
    for (int k = 0; k < 8; k++)
      add(1, 8'(k), 24'h300000 + 24'(k), 1, 3'd5, 1, 32'h05200005, 0, 16'd2, 16'd1, 0, "c_wr");
    add(0, 0, 0, 1, 3'd5, 1, 32'h05200005, 1, 16'd3, 16'd1, 0, "c_swap");
    add(1, 8'h00, 24'h400000, 1, 3'd5, 1, 32'h05300005, 0, 16'd3, 16'd1, 0, "c_new");
    for (int k = 1; k < 8; k++)
      add(1, 8'(k), 24'h400000 + 24'(k), 0, 0, 0, 32'h0, 0, 16'd3, 16'd1, 0, "d_wr");
    add(0, 0, 0, 0, 0, 0, 32'h0, 1, 16'd4, 16'd1, 0, "d_drdy");
    add(0, 0, 0, 1, 3'd0, 1, 32'h00400000, 0, 16'd4, 16'd1, 0, "d_rd0");

    // Illegal channel 10 and an ERR sample on ch3, then ch3 rewritten.
    for (int k = 0; k < 3; k++)
      add(1, 8'(k), 24'h500000 + 24'(k), 0, 0, 0, 32'h0, 0, 16'd4, 16'd1, 0, "e_wr");
    add(1, 8'h0A, 24'hDEAD00, 0, 0, 0, 32'h0, 0, 16'd4, 16'd1, 1, "e_ill");
    add(1, 8'h43, 24'h5000EE, 0, 0, 0, 32'h0, 0, 16'd4, 16'd1, 1, "e_err3");
    add(1, 8'h03, 24'h500003, 0, 0, 0, 32'h0, 0, 16'd4, 16'd1, 1, "e_rew3");
    for (int k = 4; k < 8; k++)
      add(1, 8'(k), 24'h500000 + 24'(k), 0, 0, 0, 32'h0, 0, 16'd4, 16'd1, 1, "e_wr");
    add(0, 0, 0, 0, 0, 0, 32'h0, 1, 16'd5, 16'd1, 1, "e_drdy");
    add(0, 0, 0, 1, 3'd3, 1, 32'h03500003, 0, 16'd5, 16'd1, 1, "e_rd3");
    add(0, 0, 0, 1, 3'd2, 1, 32'h02500002, 0, 16'd5, 16'd1, 1, "e_rd2");

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_drdy", 32'(drdy), 32'h0);
    check("rst_dout", bram_dout, 32'h0);
    check("rst_fc", 32'(frame_cnt), 32'h0);
    check("rst_dc", 32'(drop_cnt), 32'h0);
    check("rst_err", 32'(err_flag), 32'h0);
    check("rst4_dout", bram_dout_4, 32'h0);
    check("rst4_fc", 32'(frame_cnt_4), 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // ---- apply table ----
    foreach (vecs[i]) begin
      @(negedge clk);
      s_valid = vecs[i].v; s_status = vecs[i].st; s_data = vecs[i].d;
      bram_en = vecs[i].en; bram_addr = vecs[i].a;
      tick();
      check($sformatf("%s[%0d].drdy", vecs[i].name, i), 32'(drdy), 32'(vecs[i].drdy));
      check($sformatf("%s[%0d].frame_cnt", vecs[i].name, i), 32'(frame_cnt), 32'(vecs[i].fc));
      check($sformatf("%s[%0d].drop_cnt", vecs[i].name, i), 32'(drop_cnt), 32'(vecs[i].dc));
      check($sformatf("%s[%0d].err_flag", vecs[i].name, i), 32'(err_flag), 32'(vecs[i].err));
      if (vecs[i].chk)
        check($sformatf("%s[%0d].dout", vecs[i].name, i), bram_dout, vecs[i].dout);
    end

    // ---- reset mid-frame ----
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      s_valid = 1'b1; s_status = 8'(k); s_data = 24'h600000 + 24'(k); bram_en = 1'b0;
      tick();
    end
    @(negedge clk);
    s_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("arst_drdy", 32'(drdy), 32'h0);
    check("arst_dout", bram_dout, 32'h0);
    check("arst_fc", 32'(frame_cnt), 32'h0);
    check("arst_dc", 32'(drop_cnt), 32'h0);
    check("arst_err", 32'(err_flag), 32'h0);
    s_valid = 1'b1; s_status = 8'h07; s_data = 24'h600007;
    tick();
    check("arst_hold_drdy", 32'(drdy), 32'h0);
    check("arst_hold_fc", 32'(frame_cnt), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    s_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      s_valid = 1'b1; s_status = 8'(k); s_data = 24'h700000 + 24'(k);
      tick();
      check($sformatf("r_wr%0d_drdy", k), 32'(drdy), 32'h0);
      check($sformatf("r_wr%0d_fc", k), 32'(frame_cnt), 32'h0);
    end
    @(negedge clk);
    s_valid = 1'b0; bram_en = 1'b1; bram_addr = 3'd6;
    tick();
    check("r_drdy", 32'(drdy), 32'h1);
    check("r_fc", 32'(frame_cnt), 32'h1);
    check("r_dc", 32'(drop_cnt), 32'h0);
    check("r_swap_dout", bram_dout, 32'h0);
    tick();
    check("r_drdy_low", 32'(drdy), 32'h0);
    check("r_rd6", bram_dout, 32'h06700006);
    @(negedge clk);
    bram_en = 1'b0;

    // ---- 4-channel instance, status byte disabled ----
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_valid_4 = 1'b1; s_status_4 = 8'h80 | 8'(k); s_data_4 = 24'h900000 + 24'(k);
      tick();
      check($sformatf("n4_wr%0d_drdy", k), 32'(drdy_4), 32'h0);
    end
    @(negedge clk);
    s_valid_4 = 1'b0;
    tick();
    check("n4_drdy", 32'(drdy_4), 32'h1);
    check("n4_fc", 32'(frame_cnt_4), 32'h1);
    check("n4_err", 32'(err_flag_4), 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bram_en_4 = 1'b1; bram_addr_4 = 3'(k);
      tick();
      check($sformatf("n4_rd%0d", k), bram_dout_4,
            (k < 4) ? (32'h00900000 + 32'(k)) : 32'h0);
    end
    @(negedge clk);
    bram_en_4 = 1'b0;
    s_valid_4 = 1'b1; s_status_4 = 8'h05; s_data_4 = 24'h123456;
    tick();
    check("n4_ill_err", 32'(err_flag_4), 32'h1);
    @(negedge clk);
    s_valid_4 = 1'b0;
    tick();
    check("n4_ill_nodrdy", 32'(drdy_4), 32'h0);
    check("n4_ill_fc", 32'(frame_cnt_4), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
